// File: rtl/key_pkg.sv
// Shared key-handling definitions: one-hot decoder states and debounced level constants.
package key_pkg;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_PRESS1    = 5'b00010,
    ST_WAIT2     = 5'b00100,
    ST_PRESS2    = 5'b01000,
    ST_LONG_HOLD = 5'b10000
  } key_fsm_t;

  // Debounced key_state levels, common with the debouncer.
  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_event_decoder.sv
// Classifies debounced key activity into single/double/long-press pulses.
// Optional auto-repeat in long hold is enabled with `define KEY_REPEAT_EN.
module key_event_decoder
  import key_pkg::*;
#(
  parameter int LONG_CNT    = 50_000_000,
  parameter int DBL_GAP_CNT = 15_000_000,
  parameter int REPEAT_CNT  = 10_000_000,
  parameter int CNT_W       = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic key_flag,
  input  logic key_state,
  output logic evt_single,
  output logic evt_double,
  output logic evt_long,
  output logic evt_repeat,
  output logic key_busy
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_GAP_CNT - 1);
  // The timer keeps running in LONG_HOLD; parking it here keeps it from wrapping.
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(max3(LONG_CNT, DBL_GAP_CNT, REPEAT_CNT));

  key_fsm_t         state_reg, state_next;
  logic [CNT_W-1:0] timer_reg;
  logic             single_reg, double_reg, long_reg, busy_reg;
  logic             single_next, double_next, long_next;
  logic             key_press, key_release;

  assign key_press   = key_flag && (key_state == KEY_PRESSED);
  assign key_release = key_flag && (key_state == KEY_RELEASED);

  always_comb begin
    state_next  = state_reg;
    single_next = 1'b0;
    double_next = 1'b0;
    long_next   = 1'b0;
    // Key flags are checked before timer terminals so a flag wins a tie.
    case (state_reg)
      ST_IDLE: begin
        if (key_press) state_next = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (key_release) begin
          state_next = ST_WAIT2;
        end else if (timer_reg == LONG_LAST) begin
          long_next  = 1'b1;
          state_next = ST_LONG_HOLD;
        end
      end
      ST_WAIT2: begin
        if (key_press) begin
          state_next = ST_PRESS2;
        end else if (timer_reg == DBL_LAST) begin
          single_next = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      ST_PRESS2: begin
        if (key_release) begin
          double_next = 1'b1;
          state_next  = ST_IDLE;
        end else if (timer_reg == LONG_LAST) begin
          long_next  = 1'b1;
          state_next = ST_LONG_HOLD;
        end
      end
      ST_LONG_HOLD: begin
        if (key_release) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      timer_reg  <= '0;
      single_reg <= 1'b0;
      double_reg <= 1'b0;
      long_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      single_reg <= single_next;
      double_reg <= double_next;
      long_reg   <= long_next;
      busy_reg   <= (state_next != ST_IDLE);
      if (state_next != state_reg) begin
        timer_reg <= '0;
      end else if (state_reg != ST_IDLE && timer_reg != CNT_SAT) begin
        timer_reg <= timer_reg + 1'b1;
      end
    end
  end

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CNT - 1);

  logic [CNT_W-1:0] rep_cnt_reg;
  logic             repeat_reg, repeat_next;
  logic             hold_stay;

  assign hold_stay   = (state_reg == ST_LONG_HOLD) && (state_next == ST_LONG_HOLD);
  assign repeat_next = hold_stay && (rep_cnt_reg == REP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt_reg <= '0;
      repeat_reg  <= 1'b0;
    end else begin
      repeat_reg <= repeat_next;
      if (!hold_stay || rep_cnt_reg == REP_LAST) begin
        rep_cnt_reg <= '0;
      end else begin
        rep_cnt_reg <= rep_cnt_reg + 1'b1;
      end
    end
  end

  assign evt_repeat = repeat_reg;
`else
  assign evt_repeat = 1'b0;
`endif

  assign evt_single = single_reg;
  assign evt_double = double_reg;
  assign evt_long   = long_reg;
  assign key_busy   = busy_reg;

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder: directed scenarios plus randomized run vs reference model.
module tb_key_event_decoder;

  localparam int LONG = 100;
  localparam int GAP  = 30;
  localparam int REP  = 20;
  localparam int HMAX = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_flag = 1'b0;
  logic key_state = 1'b1;
  logic evt_single, evt_double, evt_long, evt_repeat, key_busy;

  int checks = 0;
  int errors = 0;

  int sched_cyc[8];
  bit sched_st[8];
  int sched_n;
  bit h_single[HMAX], h_double[HMAX], h_long[HMAX], h_repeat[HMAX], h_busy[HMAX];
  int n_single, n_double, n_long, n_repeat, n_busy;

  always #5 clk = ~clk;

  key_event_decoder #(
    .LONG_CNT(LONG), .DBL_GAP_CNT(GAP), .REPEAT_CNT(REP), .CNT_W(26)
  ) dut (
    .clk(clk), .rst(rst), .key_flag(key_flag), .key_state(key_state),
    .evt_single(evt_single), .evt_double(evt_double), .evt_long(evt_long),
    .evt_repeat(evt_repeat), .key_busy(key_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sched_add(input int c, input bit st);
    sched_cyc[sched_n] = c;
    sched_st[sched_n]  = st;
    sched_n++;
  endtask

  // Cycle i starts at a rising edge; outputs are recorded and flags applied at edge+1.
  task automatic run_sched(input int n);
    n_single = 0; n_double = 0; n_long = 0; n_repeat = 0; n_busy = 0;
    for (int i = 0; i < n; i++) begin
      h_single[i] = evt_single; h_double[i] = evt_double; h_long[i] = evt_long;
      h_repeat[i] = evt_repeat; h_busy[i] = key_busy;
      n_single += int'(evt_single); n_double += int'(evt_double);
      n_long += int'(evt_long); n_repeat += int'(evt_repeat); n_busy += int'(key_busy);
      key_flag = 1'b0;
      key_state = 1'b1;
      for (int k = 0; k < sched_n; k++) begin
        if (sched_cyc[k] == i) begin
          key_flag = 1'b1;
          key_state = sched_st[k];
        end
      end
      tick();
    end
    key_flag = 1'b0;
    key_state = 1'b1;
    sched_n = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({evt_single, evt_double, evt_long, evt_repeat, key_busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000",
               {evt_single, evt_double, evt_long, evt_repeat, key_busy});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    sched_n = 0;
    sched_add(0, 1'b0); sched_add(10, 1'b1);
    run_sched(80);
    checks++; if (h_single[41] !== 1'b1) begin errors++; $display("FAIL single_at_41: got %0b want 1", h_single[41]); end
    checks++; if (n_single != 1) begin errors++; $display("FAIL single_count: got %0d want 1", n_single); end
    checks++; if (n_double + n_long + n_repeat != 0) begin errors++; $display("FAIL single_other_evts: got %0d want 0", n_double + n_long + n_repeat); end
    checks++; if (h_busy[40] !== 1'b1) begin errors++; $display("FAIL single_busy_40: got %0b want 1", h_busy[40]); end
    checks++; if (h_busy[41] !== 1'b0) begin errors++; $display("FAIL single_busy_41: got %0b want 0", h_busy[41]); end
  endtask

  task automatic test_double();
    sched_n = 0;
    sched_add(0, 1'b0); sched_add(10, 1'b1); sched_add(25, 1'b0); sched_add(35, 1'b1);
    run_sched(90);
    checks++; if (h_double[36] !== 1'b1) begin errors++; $display("FAIL double_at_36: got %0b want 1", h_double[36]); end
    checks++; if (n_double != 1) begin errors++; $display("FAIL double_count: got %0d want 1", n_double); end
    checks++; if (n_single + n_long != 0) begin errors++; $display("FAIL double_other_evts: got %0d want 0", n_single + n_long); end
    checks++; if (h_busy[36] !== 1'b0) begin errors++; $display("FAIL double_busy_36: got %0b want 0", h_busy[36]); end
  endtask

  task automatic test_long_repeat();
    sched_n = 0;
    sched_add(0, 1'b0); sched_add(165, 1'b1);
    run_sched(200);
    checks++; if (h_long[101] !== 1'b1) begin errors++; $display("FAIL long_at_101: got %0b want 1", h_long[101]); end
    checks++; if (n_long != 1) begin errors++; $display("FAIL long_count: got %0d want 1", n_long); end
    checks++; if (n_single + n_double != 0) begin errors++; $display("FAIL long_other_evts: got %0d want 0", n_single + n_double); end
    checks++; if (h_busy[165] !== 1'b1 || h_busy[166] !== 1'b0) begin errors++; $display("FAIL long_busy_release: got %0b%0b want 10", h_busy[165], h_busy[166]); end
`ifdef KEY_REPEAT_EN
    checks++; if (n_repeat != 3) begin errors++; $display("FAIL repeat_count: got %0d want 3", n_repeat); end
    checks++;
    if ({h_repeat[121], h_repeat[141], h_repeat[161]} !== 3'b111) begin
      errors++;
      $display("FAIL repeat_times: got %b want 111", {h_repeat[121], h_repeat[141], h_repeat[161]});
    end
`else
    checks++; if (n_repeat != 0) begin errors++; $display("FAIL repeat_disabled: got %0d want 0", n_repeat); end
`endif
  endtask

  task automatic test_tie_and_stray();
    sched_n = 0;
    sched_add(0, 1'b1);
    run_sched(40);
    checks++;
    if (n_single + n_double + n_long + n_repeat + n_busy != 0) begin
      errors++;
      $display("FAIL stray_release: got %0d activity want 0", n_single + n_double + n_long + n_repeat + n_busy);
    end
    sched_add(0, 1'b0); sched_add(100, 1'b1);
    run_sched(160);
    checks++; if (n_long != 0) begin errors++; $display("FAIL tie_no_long: got %0d want 0", n_long); end
    checks++; if (h_single[131] !== 1'b1 || n_single != 1) begin errors++; $display("FAIL tie_single_131: got %0b/%0d want 1/1", h_single[131], n_single); end
  endtask

  task automatic test_mid_reset();
    sched_n = 0;
    sched_add(0, 1'b0); sched_add(10, 1'b1);
    run_sched(31);
    checks++; if (key_busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy: got %0b want 1", key_busy); end
    rst = 1'b1;
    #1;
    checks++;
    if ({evt_single, evt_double, evt_long, evt_repeat, key_busy} !== 5'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got %b want 00000",
               {evt_single, evt_double, evt_long, evt_repeat, key_busy});
    end
    #2 rst = 1'b0;
    tick();
    run_sched(60);
    checks++;
    if (n_single + n_double + n_long + n_busy != 0) begin
      errors++;
      $display("FAIL post_reset_quiet: got %0d activity want 0", n_single + n_double + n_long + n_busy);
    end
  endtask

  task automatic test_back_to_back();
    sched_n = 0;
    sched_add(0, 1'b0); sched_add(10, 1'b1); sched_add(25, 1'b0);
    sched_add(35, 1'b1); sched_add(36, 1'b0); sched_add(46, 1'b1);
    run_sched(100);
    checks++; if (h_double[36] !== 1'b1 || n_double != 1) begin errors++; $display("FAIL b2b_double: got %0b/%0d want 1/1", h_double[36], n_double); end
    checks++; if (h_single[77] !== 1'b1 || n_single != 1) begin errors++; $display("FAIL b2b_single: got %0b/%0d want 1/1", h_single[77], n_single); end
  endtask

  // Reference: phase 0 idle, 1 first press, 2 gap, 3 second press, 4 held;
  // "age" is cycles since the phase began, from absolute timestamps.
  task automatic test_random();
    int rates[6] = '{5, 40, 300, 10, 80, 20};
    int phase, nphase, t_enter, cyc, age, rate;
    bit f, s, pr, rl, es, ed, el, er;
    logic [4:0] exp_v, obs;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    phase = 0; t_enter = 0; cyc = 0; exp_v = '0;
    for (int chunk = 0; chunk < 6 && errors < 20; chunk++) begin
      rate = rates[chunk];
      for (int j = 0; j < 500 && errors < 20; j++) begin
        obs = {evt_single, evt_double, evt_long, evt_repeat, key_busy};
        checks++;
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL random_cycle_%0d: got %b want %b (sdlrb)", cyc, obs, exp_v);
        end
        f = ($urandom_range(0, 999) < rate);
        s = $urandom_range(0, 1) == 1;
        key_flag = f;
        key_state = s;
        pr = f && !s;
        rl = f && s;
        age = cyc - t_enter;
        nphase = phase;
        {es, ed, el, er} = 4'b0;
        case (phase)
          0: if (pr) nphase = 1;
          1: if (rl) nphase = 2; else if (age == LONG - 1) begin el = 1; nphase = 4; end
          2: if (pr) nphase = 3; else if (age == GAP - 1) begin es = 1; nphase = 0; end
          3: if (rl) begin ed = 1; nphase = 0; end
             else if (age == LONG - 1) begin el = 1; nphase = 4; end
          default: begin
            if (rl) nphase = 0;
`ifdef KEY_REPEAT_EN
            else if ((age + 1) % REP == 0) er = 1;
`endif
          end
        endcase
        if (nphase != phase) t_enter = cyc + 1;
        phase = nphase;
        exp_v = {es, ed, el, er, phase != 0};
        cyc++;
        tick();
      end
    end
    key_flag = 1'b0;
    key_state = 1'b1;
  endtask

  initial begin
    sched_n = 0;
    #1;
    test_reset();
    test_single();
    test_double();
    test_long_repeat();
    test_tie_and_stray();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
